r0_serial_drain: RTL
====================

# r0_serial_drain

Output stage R0 of the two-stage pipeline, with a serial drain. It captures the P1 word when the pipeline controller pulses `ld_r0`, then shifts the word out LSB-first on a serial line at a programmable bit rate. It returns `ld_ready`, which drives the controller's `Ld` input. The controller holds in its full/wait states until this stage reports ready.

## Interface
- `WIDTH`, default 8: word width of P1/R0; ≥2.
- `DIV`, default 1: clock cycles per serial bit; ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ld_r0`  in  1  load strobe from the pipeline controller (its LD_R0 output); sampled each edge.
- `p1_data`  in  WIDTH  P1 register contents; captured when `ld_r0` is accepted.
- `ld_ready`  out  1  stage can accept a word; drives the controller's `Ld`.
- `sdo`  out  1  serial data out.
- `sdo_valid`  out  1  `sdo` carries a data bit this cycle.
- `frame_start`  out  1  first cycle of bit 0 of a word.
- `word_count`  out  8  count of fully drained words, wraps 255→0.
- `overrun_err`  out  1  sticky: `ld_r0` arrived while not ready.

## Operation
- States: IDLE and SHIFT. All outputs derive from registered state; there is no combinational input→output path.
- IDLE:
  - `ld_ready`=1, `sdo`=0, `sdo_valid`=0.
  - When `ld_r0`=1: R0 shift register ← `p1_data`, bit counter ← 0, divide counter ← 0, go to SHIFT.
- SHIFT:
  - `ld_ready`=0, `sdo_valid`=1, `sdo`=R0[0].
  - Divide counter counts 0..DIV-1. At DIV-1 it wraps to 0, R0 shifts right by one (MSB fill 0), and the bit counter increments.
  - When the bit counter = WIDTH-1 and the divide counter = DIV-1: go to IDLE and increment `word_count` mod 256.
- `frame_start`=1 only when in SHIFT with bit counter = 0 and divide counter = 0.
- If `ld_r0`=1 while in SHIFT:
  - The word is ignored; R0 and the counters are unaffected.
  - `overrun_err` ← 1 and stays 1 until `rst`.
- Counter widths: bit counter uses clog2(WIDTH) bits; divide counter uses max(1, clog2(DIV)) bits.
- Reset values:
  - State IDLE, R0=0, all counters 0, `word_count`=0, `overrun_err`=0.
  - Outputs during and after reset: `ld_ready`=1, `sdo`=0, `sdo_valid`=0, `frame_start`=0.
- Reset mid-word: the word is abandoned, `word_count` does not increment, and the stage is ready the first cycle after `rst` deasserts.
- `rst` takes priority over `ld_r0` in the same cycle.

## Timing
- `ld_r0` accepted at edge N (IDLE):
  - SHIFT is active for cycles N+1 .. N+WIDTH·DIV.
  - Bit k is on `sdo` for cycles N+1+k·DIV .. N+(k+1)·DIV.
  - `frame_start` is high in cycle N+1 only.
- `ld_ready` falls in cycle N+1 and rises again in cycle N+1+WIDTH·DIV.
- `word_count` shows the new value in cycle N+1+WIDTH·DIV.
- Minimum word-to-word spacing is WIDTH·DIV+1 cycles: one IDLE cycle is mandatory between words.
- With DIV=1, one bit shifts out per cycle.
- The controller samples `ld_ready` as `Ld` in the same cycle it is presented. Because `ld_ready` is registered-state-derived, a one-cycle `ld_ready` IDLE window is sufficient for acceptance.

## Test plan
- WIDTH=8, DIV=1 after reset:
  - Expect `ld_ready`=1, `sdo_valid`=0, `word_count`=0.
  - Pulse `ld_r0` with `p1_data`=8'hA5 → `sdo` = 1,0,1,0,0,1,0,1 in cycles N+1..N+8, `frame_start` only in N+1, `ld_ready`=1 and `word_count`=1 in N+9.
- DIV=3, `p1_data`=8'h81 → each bit is held 3 cycles, SHIFT lasts 24 cycles, and `sdo` is high in cycles N+1..N+3 and N+22..N+24.
- Back-to-back:
  - Accept 8'h0F, then pulse `ld_r0` again in cycle N+4 with 8'hFF → the second word is ignored, `overrun_err`=1, and the 8'h0F serial stream is unchanged.
  - Pulse again in cycle N+9 → 8'hFF is accepted and `overrun_err` stays 1.
- Reset mid-word: assert `rst` in cycle N+4 of a word → the next cycle shows `ld_ready`=1, `sdo_valid`=0, `word_count`=0, `overrun_err`=0.
- Wrap-around: drain 256 words (DIV=1) → `word_count` returns to 0 after the 256th and read 255 after the 255th.
- Simultaneous `rst`=1 and `ld_r0`=1 → no capture; the stage is IDLE with R0=0 afterward.

Source files
------------

// File: rtl/r0_serial_drain.sv
// Output stage R0: captures the P1 word on ld_r0 and drains it LSB-first on sdo
// at DIV clocks per bit, reporting ld_ready back to the pipeline controller.
module r0_serial_drain #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_r0,
  input  logic [WIDTH-1:0] p1_data,
  output logic             ld_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             frame_start,
  output logic [7:0]       word_count,
  output logic             overrun_err
);

  // state | meaning
  // IDLE  | ready for a word, serial line quiet
  // SHIFT | draining R0, one bit every DIV cycles

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r0_q, r0_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic [7:0]       wc_q, wc_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r0_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      wc_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      wc_q    <= wc_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    bit_d   = bit_q;
    div_d   = div_q;
    wc_d    = wc_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (ld_r0) begin
          r0_d    = p1_data;
          bit_d   = '0;
          div_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A load while busy is dropped; only the sticky flag records it.
        if (ld_r0) ovr_d = 1'b1;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          r0_d  = r0_q >> 1;
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = IDLE;
            wc_d    = wc_q + 8'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_ready    = (state_q == IDLE);
  assign sdo_valid   = (state_q == SHIFT);
  assign sdo         = sdo_valid & r0_q[0];
  assign frame_start = sdo_valid && (bit_q == '0) && (div_q == '0);
  assign word_count  = wc_q;
  assign overrun_err = ovr_q;

endmodule
